way_pred_lookup_ctrl: RTL and testbench

- Lookup initiator that consumes the L1 way predictor.
- Per request, it reads the predictor table, probes the predicted way's tag first, and on mismatch probes the remaining ways sequentially. It then returns hit/miss plus way, and writes the resolved way back to the predictor.
- Sits between the L1 request pipeline and the tag array, driving the predictor's index/update side.

---
 rtl/way_pred_lookup_if.sv | 27 ++
 rtl/way_pred_lookup_ctrl.sv | 148 ++++++++++++++
 tb/tb_way_pred_lookup_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/way_pred_lookup_if.sv
// Request/response handshake between the L1 request pipeline and the
// way-predicted lookup controller.
interface way_pred_lookup_if #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 20,
    parameter int WAY_BITS   = 2
);
    logic                  req_valid;
    logic                  req_ready;
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_hit;
    logic [WAY_BITS-1:0]   resp_way;
    logic                  resp_pred_ok;

    modport master (
        output req_valid, req_index, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_hit, resp_way, resp_pred_ok
    );

    modport slave (
        input  req_valid, req_index, req_tag, resp_ready,
        output req_ready, resp_valid, resp_hit, resp_way, resp_pred_ok
    );
endinterface

// File: rtl/way_pred_lookup_ctrl.sv
// Lookup controller: probes the predicted way first, then the remaining ways
// in ascending order, and trains the predictor when the hit lands elsewhere.
module way_pred_lookup_ctrl #(
    parameter int NUM_SETS   = 64,
    parameter int NUM_WAYS   = 4,
    parameter int TAG_BITS   = 20,
    parameter int INDEX_BITS = $clog2(NUM_SETS),
    parameter int WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    parameter int STAT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    way_pred_lookup_if.slave      bus,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic [WAY_BITS-1:0]   pred_way,
    output logic                  pred_update_en,
    output logic [WAY_BITS-1:0]   pred_actual_way,
    output logic                  tag_rd_en,
    output logic [INDEX_BITS-1:0] tag_rd_index,
    output logic [WAY_BITS-1:0]   tag_rd_way,
    input  logic [TAG_BITS-1:0]   tag_rd_tag,
    input  logic                  tag_rd_valid,
    output logic [STAT_BITS-1:0]  stat_pred_hit,
    output logic [STAT_BITS-1:0]  stat_pred_miss,
    output logic [STAT_BITS-1:0]  stat_cache_miss
);
    typedef enum logic [1:0] {IDLE, PROBE, CHECK, RESP} state_t;

    state_t                state_q;
    logic [INDEX_BITS-1:0] idx_q;
    logic [TAG_BITS-1:0]   tag_q;
    logic [WAY_BITS-1:0]   pw_q;
    logic [WAY_BITS-1:0]   k_q;
    logic                  tag_rd_en_q;
    logic                  resp_valid_q;
    logic                  resp_hit_q;
    logic [WAY_BITS-1:0]   resp_way_q;
    logic                  resp_ok_q;
    logic [STAT_BITS-1:0]  pred_hit_q, pred_miss_q, cache_miss_q;

    logic [WAY_BITS-1:0]   probe_way;
    logic [WAY_BITS-1:0]   k_m1;
    logic [WAY_BITS-1:0]   pw_in;
    logic                  match;
    logic                  last_probe;

    function automatic logic [STAT_BITS-1:0] sat_inc(input logic [STAT_BITS-1:0] v);
        return (&v) ? v : v + STAT_BITS'(1);
    endfunction

    // An out-of-range prediction would never be probed; fold it onto way 0.
    assign pw_in      = (32'(pred_way) < NUM_WAYS) ? pred_way : '0;
    assign k_m1       = k_q - WAY_BITS'(1);
    assign match      = tag_rd_valid && (tag_rd_tag == tag_q);
    assign last_probe = (k_q == WAY_BITS'(NUM_WAYS - 1));

    // Probe k>=1 walks ways ascending, skipping the already-probed prediction.
    always_comb begin
        probe_way = pw_q;
        if (k_q != '0)
            probe_way = (k_m1 < pw_q) ? k_m1 : k_q;
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_hit     = resp_hit_q;
    assign bus.resp_way     = resp_way_q;
    assign bus.resp_pred_ok = resp_ok_q;

    assign pred_index      = (state_q == IDLE) ? bus.req_index : idx_q;
    assign pred_update_en  = (state_q == CHECK) && match && (k_q != '0);
    assign pred_actual_way = pred_update_en ? probe_way : '0;

    assign tag_rd_en    = tag_rd_en_q;
    assign tag_rd_index = idx_q;
    assign tag_rd_way   = probe_way;

    assign stat_pred_hit   = pred_hit_q;
    assign stat_pred_miss  = pred_miss_q;
    assign stat_cache_miss = cache_miss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            tag_q        <= '0;
            pw_q         <= '0;
            k_q          <= '0;
            tag_rd_en_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            resp_ok_q    <= 1'b0;
            pred_hit_q   <= '0;
            pred_miss_q  <= '0;
            cache_miss_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        idx_q       <= bus.req_index;
                        tag_q       <= bus.req_tag;
                        pw_q        <= pw_in;
                        k_q         <= '0;
                        tag_rd_en_q <= 1'b1;
                        state_q     <= PROBE;
                    end
                end
                PROBE: begin
                    tag_rd_en_q <= 1'b0;
                    state_q     <= CHECK;
                end
                CHECK: begin
                    if (match) begin
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        resp_way_q   <= probe_way;
                        resp_ok_q    <= (k_q == '0);
                        if (k_q == '0) pred_hit_q  <= sat_inc(pred_hit_q);
                        else           pred_miss_q <= sat_inc(pred_miss_q);
                        state_q      <= RESP;
                    end else if (last_probe) begin
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b0;
                        resp_way_q   <= '0;
                        resp_ok_q    <= 1'b0;
                        cache_miss_q <= sat_inc(cache_miss_q);
                        state_q      <= RESP;
                    end else begin
                        k_q         <= k_q + WAY_BITS'(1);
                        tag_rd_en_q <= 1'b1;
                        state_q     <= PROBE;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_hit_q   <= 1'b0;
                        resp_way_q   <= '0;
                        resp_ok_q    <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_way_pred_lookup_ctrl.sv
// Directed bench for way_pred_lookup_ctrl: small tag-array and predictor
// models around the DUT, hand-computed expectations per vector.
module tb_way_pred_lookup_ctrl;
    localparam int NS  = 64;
    localparam int NW  = 4;
    localparam int TGB = 20;
    localparam int IB  = 6;
    localparam int WB  = 2;
    localparam int SB  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    way_pred_lookup_if #(.INDEX_BITS(IB), .TAG_BITS(TGB), .WAY_BITS(WB)) bus();

    logic [IB-1:0]  pred_index;
    logic [WB-1:0]  pred_way;
    logic           pred_update_en;
    logic [WB-1:0]  pred_actual_way;
    logic           tag_rd_en;
    logic [IB-1:0]  tag_rd_index;
    logic [WB-1:0]  tag_rd_way;
    logic [TGB-1:0] tag_rd_tag = '0;
    logic           tag_rd_valid = 1'b0;
    logic [SB-1:0]  stat_pred_hit, stat_pred_miss, stat_cache_miss;

    way_pred_lookup_ctrl #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_BITS(TGB), .STAT_BITS(SB)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .pred_index(pred_index), .pred_way(pred_way),
        .pred_update_en(pred_update_en), .pred_actual_way(pred_actual_way),
        .tag_rd_en(tag_rd_en), .tag_rd_index(tag_rd_index), .tag_rd_way(tag_rd_way),
        .tag_rd_tag(tag_rd_tag), .tag_rd_valid(tag_rd_valid),
        .stat_pred_hit(stat_pred_hit), .stat_pred_miss(stat_pred_miss),
        .stat_cache_miss(stat_cache_miss)
    );

    logic [TGB-1:0] tmem [NS][NW];
    logic           tval [NS][NW];
    logic [WB-1:0]  ptab [NS];
    int             cyc = 0;
    int             upd_cnt = 0;
    logic [WB-1:0]  upd_way = '0;
    logic [WB-1:0]  probes[$];

    assign pred_way = ptab[pred_index];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tag_rd_en) begin
            tag_rd_tag   <= tmem[tag_rd_index][tag_rd_way];
            tag_rd_valid <= tval[tag_rd_index][tag_rd_way];
            probes.push_back(tag_rd_way);
        end
        if (pred_update_en) begin
            upd_cnt <= upd_cnt + 1;
            upd_way <= pred_actual_way;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int   r_lat;
    logic r_hit, r_ok;
    logic [WB-1:0] r_way;

    // Issue one lookup, wait for the response, hold resp_ready low for `hold`
    // cycles checking stability, then complete the handshake.
    task automatic do_req(input logic [IB-1:0] idx, input logic [TGB-1:0] tg, input int hold);
        int  acc;
        bit  seen;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_index = idx;
        bus.req_tag   = tg;
        chk("req_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1;
        end
        if (!seen) begin
            chk("resp_timeout", 0, 1);
            return;
        end
        r_lat = cyc - acc;
        r_hit = bus.resp_hit;
        r_way = bus.resp_way;
        r_ok  = bus.resp_pred_ok;
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", bus.resp_valid, 1);
            chk("hold_hit", bus.resp_hit, 32'(r_hit));
            chk("hold_way", bus.resp_way, 32'(r_way));
            chk("hold_req_ready", bus.req_ready, 0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    int p0, u0;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_index  = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;
        for (int s = 0; s < NS; s++) begin
            ptab[s] = '0;
            for (int w = 0; w < NW; w++) begin
                tmem[s][w] = '0;
                tval[s][w] = 1'b0;
            end
        end
        // set 5: predicted hit in way 2
        tmem[5][0] = 20'h11111; tval[5][0] = 1'b1;
        tmem[5][2] = 20'hABCDE; tval[5][2] = 1'b1;
        ptab[5] = 2'd2;
        // set 7: predicted 2, real hit in way 3
        for (int w = 0; w < 3; w++) begin tmem[7][w] = 20'h22222; tval[7][w] = 1'b1; end
        tmem[7][3] = 20'h07777; tval[7][3] = 1'b1;
        ptab[7] = 2'd2;
        // set 9: miss everywhere
        for (int w = 0; w < NW; w++) begin tmem[9][w] = 20'h33333; tval[9][w] = 1'b1; end
        ptab[9] = 2'd1;
        // set 11: way 0 tag matches but the line is invalid
        tmem[11][0] = 20'h55555; tval[11][0] = 1'b0;
        tmem[11][1] = 20'h12345; tval[11][1] = 1'b1;
        tmem[11][2] = 20'h55555; tval[11][2] = 1'b1;
        ptab[11] = 2'd0;
        // set 13: used for reset-in-CHECK
        tmem[13][0] = 20'h00001; tval[13][0] = 1'b1;
        tmem[13][1] = 20'h66666; tval[13][1] = 1'b1;
        ptab[13] = 2'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_tag_rd_en", tag_rd_en, 0);
        chk("rst_upd_en", pred_update_en, 0);
        chk("rst_stat_hit", stat_pred_hit, 0);
        chk("rst_stat_pmiss", stat_pred_miss, 0);
        chk("rst_stat_cmiss", stat_cache_miss, 0);
        rst_n = 1'b1;

        // predicted-way hit: T+3
        p0 = probes.size(); u0 = upd_cnt;
        do_req(6'd5, 20'hABCDE, 0);
        chk("c1_lat", r_lat, 2);
        chk("c1_hit", r_hit, 1);
        chk("c1_way", r_way, 2);
        chk("c1_ok", r_ok, 1);
        chk("c1_nprobe", probes.size() - p0, 1);
        chk("c1_p0", probes[p0], 2);
        chk("c1_upd", upd_cnt - u0, 0);
        chk("c1_stat_hit", stat_pred_hit, 1);

        // hit in way 3 after order 2,0,1,3: T+9
        p0 = probes.size(); u0 = upd_cnt;
        do_req(6'd7, 20'h07777, 0);
        chk("c2_lat", r_lat, 8);
        chk("c2_hit", r_hit, 1);
        chk("c2_way", r_way, 3);
        chk("c2_ok", r_ok, 0);
        chk("c2_nprobe", probes.size() - p0, 4);
        chk("c2_p0", probes[p0], 2);
        chk("c2_p1", probes[p0+1], 0);
        chk("c2_p2", probes[p0+2], 1);
        chk("c2_p3", probes[p0+3], 3);
        chk("c2_upd", upd_cnt - u0, 1);
        chk("c2_upd_way", upd_way, 3);
        chk("c2_stat_pmiss", stat_pred_miss, 1);

        // full miss, order 1,0,2,3: T+9
        p0 = probes.size(); u0 = upd_cnt;
        do_req(6'd9, 20'h44444, 0);
        chk("c3_lat", r_lat, 8);
        chk("c3_hit", r_hit, 0);
        chk("c3_way", r_way, 0);
        chk("c3_ok", r_ok, 0);
        chk("c3_p0", probes[p0], 1);
        chk("c3_p1", probes[p0+1], 0);
        chk("c3_p2", probes[p0+2], 2);
        chk("c3_p3", probes[p0+3], 3);
        chk("c3_upd", upd_cnt - u0, 0);
        chk("c3_stat_cmiss", stat_cache_miss, 1);

        // invalid line with matching tag is skipped: hit way 2 on third probe
        p0 = probes.size(); u0 = upd_cnt;
        do_req(6'd11, 20'h55555, 0);
        chk("c4_lat", r_lat, 6);
        chk("c4_hit", r_hit, 1);
        chk("c4_way", r_way, 2);
        chk("c4_ok", r_ok, 0);
        chk("c4_nprobe", probes.size() - p0, 3);
        chk("c4_upd_way", upd_way, 2);
        chk("c4_stat_pmiss", stat_pred_miss, 2);

        // back-pressure, then back-to-back request right after handshake
        do_req(6'd5, 20'hABCDE, 5);
        chk("c5_hit", r_hit, 1);
        chk("c5_way", r_way, 2);
        do_req(6'd5, 20'hABCDE, 0);
        chk("c5_b2b_lat", r_lat, 2);
        chk("c5_stat_hit", stat_pred_hit, 3);

        // reset while in CHECK of probe k=1 (which would update the predictor)
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_index = 6'd13; bus.req_tag = 20'h66666;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("c6_pre_upd", pred_update_en, 1);
        u0 = upd_cnt;
        rst_n = 1'b0;
        #1;
        chk("c6_upd_en", pred_update_en, 0);
        chk("c6_tag_rd_en", tag_rd_en, 0);
        chk("c6_resp_valid", bus.resp_valid, 0);
        chk("c6_req_ready", bus.req_ready, 1);
        chk("c6_stat_hit", stat_pred_hit, 0);
        chk("c6_stat_pmiss", stat_pred_miss, 0);
        chk("c6_stat_cmiss", stat_cache_miss, 0);
        @(posedge clk);
        #1 chk("c6_no_upd", upd_cnt - u0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = probes.size(); u0 = upd_cnt;
        do_req(6'd13, 20'h66666, 0);
        chk("c6_lat", r_lat, 4);
        chk("c6_hit", r_hit, 1);
        chk("c6_way", r_way, 1);
        chk("c6_ok", r_ok, 0);
        chk("c6_upd", upd_cnt - u0, 1);
        chk("c6_stat_pmiss", stat_pred_miss, 1);

        // saturation of the 4-bit hit counter at all-ones
        for (int i = 0; i < 16; i++) begin
            do_req(6'd5, 20'hABCDE, 0);
            if (i == 14) chk("c7_at_max", stat_pred_hit, 15);
        end
        chk("c7_sat", stat_pred_hit, 15);
        chk("c7_pmiss_kept", stat_pred_miss, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
